latch_load_ctrl: RTL and testbench

Clocked sequencer that drives the team's parameterized level-sensitive latch (`d`, `gate`, `aset`, `aclr`) from a valid/ready command stream. It converts LOAD/SET/CLR commands into glitch-free, mutually exclusive control waveforms with programmable setup, gate-width and hold windows, so the latch is never opened while its data is changing. It sits directly upstream of the latch; its outputs connect one-to-one to the latch inputs.

---
 rtl/latch_ctrl_pkg.sv | 27 ++
 rtl/latch_load_ctrl_phase_timer.sv | 25 ++
 rtl/latch_load_ctrl.sv | 163 ++++++++++++++++
 tb/tb_latch_load_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and constants for the latch load controller.
package latch_ctrl_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_NOP  = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_GATE,
    ST_HOLD,
    ST_PULSE
  } state_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_load_ctrl_phase_timer.sv
// Loadable down-counter shared by every controller phase; stops at zero.
module phase_timer #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/latch_load_ctrl.sv
// Sequencer turning LOAD/SET/CLR/NOP commands into latch d/gate/aset/aclr waveforms.
// Define LATCH_CTRL_SHADOW_EN to build the shadow copy of the latch content.
module latch_load_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned GATE_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [W-1:0]    cmd_data,
  output logic [W-1:0]    d_out,
  output logic            gate,
  output logic            aset,
  output logic            aclr,
  output logic            done,
  output logic [W-1:0]    shadow_q
);

  localparam int unsigned CW = $clog2(max3(SETUP_CYC, GATE_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_GATE  = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(GATE_CYC);

  state_t        r_state;
  cmd_op_t       r_op;
  logic [W-1:0]  r_d_out;
  logic          r_gate, r_aset, r_aclr, r_done, r_ready;
  cmd_op_t       w_op;
  logic          w_accept, w_load, w_zero;
  logic [CW-1:0] w_load_val;

  assign w_op     = cmd_op_t'(cmd_op);
  assign w_accept = cmd_valid & r_ready;

  // SET/CLR get one lead cycle in PULSE before the pulse rises; NOP passes
  // through PULSE for a single cycle so done lands with cmd_ready high.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_load = 1'b1;
        unique case (w_op)
          OP_LOAD:        w_load_val = LD_SETUP;
          OP_SET, OP_CLR: w_load_val = LD_PULSE;
          default:        w_load_val = '0;
        endcase
      end
      ST_SETUP: if (w_zero) begin
        w_load     = 1'b1;
        w_load_val = LD_GATE;
      end
      ST_GATE: if (w_zero && HOLD_CYC != 0) begin
        w_load     = 1'b1;
        w_load_val = LD_HOLD;
      end
      default: ;
    endcase
  end

  phase_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_d_out <= '0;
      r_gate  <= 1'b0;
      r_aset  <= 1'b0;
      r_aclr  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_accept) begin
          r_ready <= 1'b0;
          r_op    <= w_op;
          if (w_op == OP_LOAD) begin
            r_d_out <= cmd_data;
            r_state <= ST_SETUP;
          end else begin
            r_state <= ST_PULSE;
          end
        end
        ST_SETUP: if (w_zero) begin
          r_gate  <= 1'b1;
          r_state <= ST_GATE;
        end
        ST_GATE: if (w_zero) begin
          r_gate <= 1'b0;
          if (HOLD_CYC == 0) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: if (w_zero) begin
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_PULSE: begin
          if (w_zero) begin
            r_aset  <= 1'b0;
            r_aclr  <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_aset <= (r_op == OP_SET);
            r_aclr <= (r_op == OP_CLR);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LATCH_CTRL_SHADOW_EN
  logic [W-1:0] r_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_shadow <= '0;
    else if (r_state == ST_GATE && w_zero)
      r_shadow <= r_d_out;
    else if (r_state == ST_PULSE && w_zero) begin
      if (r_op == OP_SET)
        r_shadow <= '1;
      else if (r_op == OP_CLR)
        r_shadow <= '0;
    end
  end

  assign shadow_q = r_shadow;
`else
  assign shadow_q = '0;
`endif

  assign cmd_ready = r_ready;
  assign d_out     = r_d_out;
  assign gate      = r_gate;
  assign aset      = r_aset;
  assign aclr      = r_aclr;
  assign done      = r_done;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Self-checking bench: two controller instances against a schedule-based reference model.
module tb_latch_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v[2];
  logic [1:0] op[2];
  logic [3:0] dat[2];
  logic       rdy[2], gt[2], as[2], ac[2], dn[2];
  logic [3:0] dq[2], sq[2];

  int checks = 0;
  int errors = 0;
  int c = 0;

  int S[2] = '{1, 2};
  int G[2] = '{2, 1};
  int H[2] = '{1, 0};

  int         t_idle[2], t_done[2], g_lo[2], g_hi[2], p_lo[2], p_hi[2], t_sh[2];
  logic       p_set[2];
  logic [3:0] d_exp[2], sh_cur[2], sh_pend[2];

  always #5 clk = ~clk;

  latch_load_ctrl #(.W(4), .SETUP_CYC(1), .GATE_CYC(2), .HOLD_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v[0]), .cmd_ready(rdy[0]), .cmd_op(op[0]),
    .cmd_data(dat[0]), .d_out(dq[0]), .gate(gt[0]), .aset(as[0]), .aclr(ac[0]),
    .done(dn[0]), .shadow_q(sq[0])
  );

  latch_load_ctrl #(.W(4), .SETUP_CYC(2), .GATE_CYC(1), .HOLD_CYC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v[1]), .cmd_ready(rdy[1]), .cmd_op(op[1]),
    .cmd_data(dat[1]), .d_out(dq[1]), .gate(gt[1]), .aset(as[1]), .aclr(ac[1]),
    .done(dn[1]), .shadow_q(sq[1])
  );

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h exp %0h at cycle %0d", tag, i, got, exp, c);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      t_idle[i] = c;  t_done[i] = -1;
      g_lo[i] = 1;    g_hi[i] = 0;
      p_lo[i] = 1;    p_hi[i] = 0;   p_set[i] = 1'b0;
      d_exp[i] = '0;  sh_cur[i] = '0; sh_pend[i] = '0; t_sh[i] = -1;
    end
  endtask

  // Called just after edge c: decide acceptance and lay out the command's timeline.
  task automatic mdl_edge();
    int k;
    for (int i = 0; i < 2; i++) begin
      if (rst_n && v[i] && (c - 1) >= t_idle[i]) begin
        k = c;
        g_lo[i] = 1; g_hi[i] = 0; p_lo[i] = 1; p_hi[i] = 0;
        case (op[i])
          2'd0: begin
            d_exp[i] = dat[i];
            g_lo[i] = k + S[i];
            g_hi[i] = k + S[i] + G[i] - 1;
            t_idle[i] = k + S[i] + G[i] + H[i];
            sh_pend[i] = dat[i];
            t_sh[i] = k + S[i] + G[i];
          end
          2'd1, 2'd2: begin
            p_lo[i] = k + 1;
            p_hi[i] = k + G[i];
            p_set[i] = (op[i] == 2'd1);
            t_idle[i] = k + G[i] + 1;
            sh_pend[i] = (op[i] == 2'd1) ? 4'hF : 4'h0;
            t_sh[i] = k + G[i] + 1;
          end
          default: t_idle[i] = k + 1;
        endcase
        t_done[i] = t_idle[i];
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] sh_exp;
    bit in_p;
    for (int i = 0; i < 2; i++) begin
      if (t_sh[i] >= 0 && c >= t_sh[i]) begin
        sh_cur[i] = sh_pend[i];
        t_sh[i] = -1;
      end
`ifdef LATCH_CTRL_SHADOW_EN
      sh_exp = sh_cur[i];
`else
      sh_exp = 4'h0;
`endif
      in_p = (c >= p_lo[i] && c <= p_hi[i]);
      chk("ready",  i, 32'(rdy[i]), 32'(c >= t_idle[i]));
      chk("done",   i, 32'(dn[i]),  32'(c == t_done[i]));
      chk("gate",   i, 32'(gt[i]),  32'(c >= g_lo[i] && c <= g_hi[i]));
      chk("aset",   i, 32'(as[i]),  32'(in_p && p_set[i]));
      chk("aclr",   i, 32'(ac[i]),  32'(in_p && !p_set[i]));
      chk("d_out",  i, 32'(dq[i]),  32'(d_exp[i]));
      chk("shadow", i, 32'(sq[i]),  32'(sh_exp));
      chk("excl",   i, 32'((32'(gt[i]) + 32'(as[i]) + 32'(ac[i])) > 1), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    c++;
    mdl_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; op[i] = 2'd3; dat[i] = '0;
    end
    mdl_reset();
    repeat (2) @(negedge clk);
    chk("rst_dout", 0, 32'(dq[0]), 32'd0);
    chk("rst_gate", 0, 32'(gt[0]), 32'd0);
    rst_n = 1'b1;
    c = 0;
    mdl_reset();
    check_all();

    // LOAD 4'hA on the default instance
    v[0] = 1'b1; op[0] = 2'd0; dat[0] = 4'hA; step();
    v[0] = 1'b0; repeat (6) step();

    // SET then CLR with valid held high
    v[0] = 1'b1; op[0] = 2'd1; step();
    op[0] = 2'd2; repeat (4) step();
    v[0] = 1'b0; repeat (5) step();

    // HOLD_CYC=0 instance: LOAD 5
    v[1] = 1'b1; op[1] = 2'd0; dat[1] = 4'h5; step();
    v[1] = 1'b0; repeat (5) step();

    // valid toggled while busy
    v[0] = 1'b1; op[0] = 2'd0; dat[0] = 4'h3; step();
    op[0] = 2'd1;
    for (int j = 0; j < 3; j++) begin
      v[0] = j[0];
      step();
    end
    v[0] = 1'b0; repeat (4) step();

    // NOP
    v[0] = 1'b1; op[0] = 2'd3; step();
    v[0] = 1'b0; repeat (2) step();

    // reset during GATE, with a prior LOAD establishing shadow content
    v[0] = 1'b1; op[0] = 2'd0; dat[0] = 4'h9; step();
    v[0] = 1'b0; repeat (5) step();
    v[0] = 1'b1; dat[0] = 4'h6; step();
    v[0] = 1'b0; step();
    chk("pre_rst_gate", 0, 32'(gt[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gate",   0, 32'(gt[0]), 32'd0);
    chk("async_dout",   0, 32'(dq[0]), 32'd0);
    chk("async_shadow", 0, 32'(sq[0]), 32'd0);
    chk("async_done",   0, 32'(dn[0]), 32'd0);
    mdl_reset();
    @(posedge clk);
    c++;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    step();

    // randomized traffic on both instances
    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        v[i]   = ($urandom % 3) != 0;
        op[i]  = 2'($urandom % 4);
        dat[i] = 4'($urandom);
      end
      step();
    end
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
